// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(8,4) SECDED controller slice.
//   - operation mode and result status encodings
//   - controller FSM state encoding
//   - codeword builder used by the codec
package hamming_pkg;

  localparam logic       MODE_ENC = 1'b0;
  localparam logic       MODE_DEC = 1'b1;

  localparam logic [1:0] ST_CLEAN = 2'b00;
  localparam logic [1:0] ST_CORR  = 2'b01;
  localparam logic [1:0] ST_DBL   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  // Registered operand captured on accept.
  typedef struct packed {
    logic       mode;
    logic [7:0] data;
  } op_t;

  // Bits [6:0] are Hamming positions 1..7 = {d3,d2,d1,p4,d0,p2,p1};
  // bit 7 makes the whole byte even parity.
  function automatic logic [7:0] hamming_encode(input logic [3:0] d);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return {^c, c};
  endfunction

endpackage

// File: rtl/hamming_if.sv
// Command/result handshake bundle for hamming_ctrl.
//   in_valid/in_ready/in_mode/in_data     : command channel (producer -> controller)
//   out_valid/out_ready/out_data/out_status: result channel (controller -> consumer)
// master: the command producer / result consumer side.
// slave : the controller side.
interface hamming_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_mode;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_status;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_status
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_status
  );
endinterface

// File: rtl/hamming_secded_codec.sv
// Purely combinational SECDED Hamming(8,4) encoder/decoder.
//   mode   in  0 = encode din[3:0], 1 = decode din[7:0]
//   din    in  nibble or codeword
//   dout   out codeword (encode) or {4'b0, data} (decode)
//   status out ST_CLEAN / ST_CORR / ST_DBL (always ST_CLEAN for encode)
module hamming_secded_codec
  import hamming_pkg::*;
(
  input  logic       mode,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [1:0] status
);

  logic [2:0] syn;
  logic       par;
  logic [7:0] cw;

  always_comb begin
    dout   = '0;
    status = ST_CLEAN;
    syn    = '0;
    par    = 1'b0;
    cw     = din;
    if (mode == MODE_ENC) begin
      dout = hamming_encode(din[3:0]);
    end else begin
      syn[0] = din[0] ^ din[2] ^ din[4] ^ din[6];
      syn[1] = din[1] ^ din[2] ^ din[5] ^ din[6];
      syn[2] = din[3] ^ din[4] ^ din[5] ^ din[6];
      par    = ^din;
      if (syn != 3'd0 && par) begin
        // Syndrome names the Hamming position; position k lives in bit k-1.
        cw[syn - 3'd1] = ~din[syn - 3'd1];
        status         = ST_CORR;
      end else if (syn == 3'd0 && par) begin
        // Only the overall parity bit flipped; data bits are intact.
        status = ST_CORR;
      end else if (syn != 3'd0 && !par) begin
        status = ST_DBL;
      end
      dout = {4'b0000, cw[6], cw[5], cw[4], cw[2]};
    end
  end

endmodule

// File: rtl/hamming_ctrl.sv
// Sequencing controller around one shared SECDED Hamming(8,4) codec.
//   clk, rst_n      clock and synchronous active-low reset
//   bus (slave)     command and result handshakes (see hamming_if)
//   cnt_clr         one-cycle clear of both error counters
//   err_single_cnt  saturating count of corrected decodes
//   err_double_cnt  saturating count of uncorrectable decodes
//   busy            high whenever the FSM is not idle
// One op at a time: IDLE accepts, EXEC runs the codec, HOLD presents the
// result until the consumer takes it.
module hamming_ctrl
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  hamming_if.slave         bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_single_cnt,
  output logic [CNT_W-1:0] err_double_cnt,
  output logic             busy
);

  state_e           state_q, state_d;
  op_t              op_q;
  logic [7:0]       res_data_q;
  logic [1:0]       res_st_q;
  logic [CNT_W-1:0] single_q, double_q;

  logic [7:0]       codec_dout;
  logic [1:0]       codec_st;

  hamming_secded_codec u_codec (
    .mode   (op_q.mode),
    .din    (op_q.data),
    .dout   (codec_dout),
    .status (codec_st)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_HOLD;
      S_HOLD:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
      end
      S_HOLD:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand and result registers. The result only changes in EXEC, so it
  // is stable for the whole of HOLD regardless of back-pressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= '0;
      res_data_q <= '0;
      res_st_q   <= ST_CLEAN;
    end else begin
      if (state_q == S_IDLE && bus.in_valid) begin
        op_q.mode <= bus.in_mode;
        op_q.data <= bus.in_data;
      end
      if (state_q == S_EXEC) begin
        res_data_q <= codec_dout;
        res_st_q   <= codec_st;
      end
    end
  end

  assign bus.out_data   = res_data_q;
  assign bus.out_status = res_st_q;

  // Error counters: count once per decode in EXEC, hold at all-ones,
  // and a clear overrides a same-cycle increment.
  logic inc_single, inc_double;
  assign inc_single = (state_q == S_EXEC) && (op_q.mode == MODE_DEC) && (codec_st == ST_CORR);
  assign inc_double = (state_q == S_EXEC) && (op_q.mode == MODE_DEC) && (codec_st == ST_DBL);

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      single_q <= '0;
      double_q <= '0;
    end else begin
      if (inc_single && single_q != '1) single_q <= single_q + CNT_W'(1);
      if (inc_double && double_q != '1) double_q <= double_q + CNT_W'(1);
    end
  end

  assign err_single_cnt = single_q;
  assign err_double_cnt = double_q;

endmodule

// File: tb/tb_hamming_ctrl.sv
// Scoreboard bench for hamming_ctrl (counters built 2 bits wide so
// saturation is reachable with a handful of decodes).
module tb_hamming_ctrl;
  import hamming_pkg::*;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cnt_clr;
  logic [CNT_W-1:0] err_single_cnt, err_double_cnt;
  logic             busy;

  hamming_if bus ();

  hamming_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .cnt_clr        (cnt_clr),
    .err_single_cnt (err_single_cnt),
    .err_double_cnt (err_double_cnt),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a result is consumed on the edge following a negedge where
  // valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", {24'd0, bus.out_data}, {24'd0, e.d});
        chk("out_status", {30'd0, bus.out_status}, {30'd0, e.s});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, push its expected result, check EXEC and the
  // two-cycle latency. Optionally pulse cnt_clr during the EXEC cycle.
  task automatic send(input logic m, input logic [7:0] d,
                      input logic [7:0] ed, input logic [1:0] es, input bit clr_exec);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      cyc();
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      bus.in_valid = 1'b1;
      bus.in_mode  = m;
      bus.in_data  = d;
      sb.push_back({ed, es});
      cyc();
      bus.in_valid = 1'b0;
      chk("exec_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("exec_in_ready", {31'd0, bus.in_ready}, 32'd0);
      if (clr_exec) cnt_clr = 1'b1;
      cyc();
      cnt_clr = 1'b0;
      chk("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    cyc();
  endtask

  initial begin
    rst_n         = 1'b0;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = MODE_ENC;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_out_status", {30'd0, bus.out_status}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_single", {30'd0, err_single_cnt}, 32'd0);
    chk("rst_double", {30'd0, err_double_cnt}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Encode and clean/single-error decodes
    send(MODE_ENC, 8'h0B, 8'h55, ST_CLEAN, 1'b0); drain();
    send(MODE_DEC, 8'h55, 8'h0B, ST_CLEAN, 1'b0); drain();
    send(MODE_DEC, 8'h51, 8'h0B, ST_CORR,  1'b0); drain();
    send(MODE_DEC, 8'hD5, 8'h0B, ST_CORR,  1'b0); drain();
    chk("single_after_2", {30'd0, err_single_cnt}, 32'd2);
    chk("double_after_0", {30'd0, err_double_cnt}, 32'd0);

    // Double error
    send(MODE_DEC, 8'h56, 8'h0B, ST_DBL, 1'b0); drain();
    chk("double_after_1", {30'd0, err_double_cnt}, 32'd1);
    chk("single_unchanged", {30'd0, err_single_cnt}, 32'd2);

    // Back-pressure with a second command waiting
    bus.out_ready = 1'b0;
    send(MODE_ENC, 8'h0B, 8'h55, ST_CLEAN, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_mode  = MODE_ENC;
    bus.in_data  = 8'h03;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_out_data", {24'd0, bus.out_data}, 32'h55);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    sb.push_back({8'h1E, ST_CLEAN});
    bus.out_ready = 1'b1;
    cyc();
    chk("post_hs_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post_hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
    cyc();
    bus.in_valid = 1'b0;
    chk("second_accepted_busy", {31'd0, busy}, 32'd1);
    chk("second_accepted_in_ready", {31'd0, bus.in_ready}, 32'd0);
    drain();

    // Saturation and clear priority
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    chk("clr_single", {30'd0, err_single_cnt}, 32'd0);
    chk("clr_double", {30'd0, err_double_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(MODE_DEC, 8'h51, 8'h0B, ST_CORR, 1'b0);
      drain();
    end
    chk("single_saturated", {30'd0, err_single_cnt}, 32'd3);
    send(MODE_DEC, 8'h56, 8'h0B, ST_DBL, 1'b0); drain();
    chk("double_before_clr", {30'd0, err_double_cnt}, 32'd1);
    send(MODE_DEC, 8'hD5, 8'h0B, ST_CORR, 1'b1); drain();
    chk("clr_wins_single", {30'd0, err_single_cnt}, 32'd0);
    chk("clr_wins_double", {30'd0, err_double_cnt}, 32'd0);

    // Reset while holding a result
    send(MODE_DEC, 8'h51, 8'h0B, ST_CORR, 1'b0); drain();
    chk("single_before_rst", {30'd0, err_single_cnt}, 32'd1);
    bus.out_ready = 1'b0;
    send(MODE_ENC, 8'h0B, 8'h55, ST_CLEAN, 1'b0);
    rst_n = 1'b0;
    sb = {};
    cyc();
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst_single", {30'd0, err_single_cnt}, 32'd0);
    chk("midrst_double", {30'd0, err_double_cnt}, 32'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    send(MODE_ENC, 8'h0B, 8'h55, ST_CLEAN, 1'b0); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
